mem_refill_arbiter: RTL

Sequences line refills and dirty-line writebacks for the instruction and data caches over the single shared word-serial main-memory port. Sits between the two cache controllers and the memory model. Exports `ICacheMiss`/`DCacheMiss`, which hold the pipeline in place while a miss is pending or in service. Handles one line transaction at a time and arbitrates when both caches miss together.

---
 rtl/mem_refill_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_refill_arbiter.sv
// rtl/mem_refill_arbiter.sv - shared memory port sequencer for I/D line refills and D writebacks (option: MEM_ARB_RR_EN)
module mem_refill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          CpuRst_n,
    input  logic                          IReq,
    input  logic [ADDR_W-1:0]             IAddr,
    output logic [31:0]                   IRData,
    output logic                          IRValid,
    output logic                          IDone,
    input  logic                          DReq,
    input  logic                          DWb,
    input  logic [ADDR_W-1:0]             DAddr,
    input  logic [ADDR_W-1:0]             DWbAddr,
    output logic [$clog2(LINE_WORDS)-1:0] DWbIdx,
    input  logic [31:0]                   DWData,
    output logic [31:0]                   DRData,
    output logic                          DRValid,
    output logic                          DDone,
    output logic                          MemReq,
    output logic                          MemWe,
    output logic [ADDR_W-1:0]             MemAddr,
    output logic [31:0]                   MemWData,
    input  logic                          MemAck,
    input  logic [31:0]                   MemRData,
    output logic                          ICacheMiss,
    output logic                          DCacheMiss
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, I_FILL, D_WB, D_FILL, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic              r_owner_d;
    logic              w_any;
    logic              w_pick_d;
    logic              w_last;

    assign w_any  = IReq | DReq;
    assign w_last = (r_cnt == LAST_IDX);

`ifdef MEM_ARB_RR_EN
    logic r_last_d;

    // Round-robin: on a tie the side that did not win last time is chosen
    always_comb begin
        w_pick_d = DReq;
        if (IReq && DReq) begin
            w_pick_d = ~r_last_d;
        end
    end

    // Remember which side received the most recent grant
    always_ff @(posedge clk) begin
        if (!CpuRst_n) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && w_any) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // Fixed priority: data side wins any tie
    always_comb begin
        w_pick_d = DReq;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!CpuRst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state control outputs
    always_comb begin
        w_next  = r_state;
        MemReq  = 1'b0;
        MemWe   = 1'b0;
        IRValid = 1'b0;
        DRValid = 1'b0;
        IDone   = 1'b0;
        DDone   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (w_pick_d) begin
                        w_next = DWb ? D_WB : D_FILL;
                    end else begin
                        w_next = I_FILL;
                    end
                end
            end
            I_FILL: begin
                MemReq  = 1'b1;
                IRValid = MemAck;
                if (MemAck && w_last) begin
                    w_next = RESP;
                end
            end
            D_WB: begin
                MemReq = 1'b1;
                MemWe  = 1'b1;
                if (MemAck && w_last) begin
                    w_next = D_FILL;
                end
            end
            D_FILL: begin
                MemReq  = 1'b1;
                DRValid = MemAck;
                if (MemAck && w_last) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                IDone  = ~r_owner_d;
                DDone  = r_owner_d;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Line base, owner and word counter; base switches to the refill line after a writeback
    always_ff @(posedge clk) begin
        if (!CpuRst_n) begin
            r_cnt     <= '0;
            r_base    <= '0;
            r_owner_d <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cnt     <= '0;
                        r_owner_d <= w_pick_d;
                        if (!w_pick_d) begin
                            r_base <= IAddr & LINE_MASK;
                        end else if (DWb) begin
                            r_base <= DWbAddr & LINE_MASK;
                        end else begin
                            r_base <= DAddr & LINE_MASK;
                        end
                    end
                end
                I_FILL, D_FILL: begin
                    if (MemAck) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                D_WB: begin
                    if (MemAck) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_base <= DAddr & LINE_MASK;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath: outputs are forced to zero whenever they carry nothing meaningful
    assign MemAddr    = MemReq ? (r_base + {{(ADDR_W-OFF_W){1'b0}}, r_cnt, 2'b00}) : '0;
    assign MemWData   = (r_state == D_WB) ? DWData : '0;
    assign DWbIdx     = (r_state == D_WB) ? r_cnt : '0;
    assign IRData     = IRValid ? MemRData : '0;
    assign DRData     = DRValid ? MemRData : '0;
    assign ICacheMiss = IReq & ~IDone;
    assign DCacheMiss = DReq & ~DDone;
endmodule
